// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready input FIFO feeding a back-to-back frame serialiser.
// Optional parity bit (parity_mode port, PARITY state) is built only when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_BITS-1:0]          s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
`ifdef UART_TX_PARITY_EN
   input  logic [1:0]                    parity_mode,
`endif
   output logic                          tx,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W = $clog2(CLKS_PER_BIT * STOP_BITS);
   localparam int IDX_W = $clog2(DATA_BITS);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CLKS_PER_BIT * STOP_BITS - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
   localparam logic [PTR_W:0]   FULL      = (PTR_W + 1)'(FIFO_DEPTH);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd3;
`endif
   localparam logic [2:0] STOP   = 3'd4;

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wrPtr_q, rdPtr_q;
   logic [PTR_W:0]       count_q;
   logic                 push, pop, load;

   logic [2:0]           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
   logic                 parEn_q, parEn_d;
   logic                 parBit_q, parBit_d;
`endif

   // A pop in the same cycle never frees a slot for the incoming word.
   assign s_ready    = rst_n && (count_q != FULL);
   assign push       = s_valid && s_ready;
   assign pop        = load;
   assign fifo_level = count_q;
   assign tx         = tx_q;
   assign tx_busy    = (state_q != IDLE);

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wrPtr_q] <= s_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (push) wrPtr_q <= wrPtr_q + 1'b1;
         if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // The shift register is pre-shifted so shift_q[0] is always the next data bit to drive.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      load     = 1'b0;
`ifdef UART_TX_PARITY_EN
      parEn_d  = parEn_q;
      parBit_d = parBit_q;
`endif
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (count_q != '0) load = 1'b1;
         end
         START: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               idx_d   = '0;
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
               state_d = DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                  if (parEn_q) begin
                     state_d = PARITY;
                     tx_d    = parBit_q;
                  end else begin
                     state_d = STOP;
                     tx_d    = 1'b1;
                  end
`else
                  state_d = STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  idx_d   = idx_q + 1'b1;
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               tx_d    = 1'b1;
               state_d = STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif
         STOP: begin
            if (cnt_q == STOP_LAST) begin
               cnt_d = '0;
               if (count_q != '0) begin
                  load = 1'b1;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase

      // Parity setting is captured with the word so mid-frame changes cannot reach the line.
      if (load) begin
         state_d  = START;
         tx_d     = 1'b0;
         cnt_d    = '0;
         shift_d  = mem_q[rdPtr_q];
`ifdef UART_TX_PARITY_EN
         parEn_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
         parBit_d = (^mem_q[rdPtr_q]) ^ (parity_mode == 2'b10);
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parEn_q  <= 1'b0;
         parBit_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
         parEn_q  <= parEn_d;
         parBit_q <= parBit_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based line model checked every cycle, plus literal frame checks.
// Works with or without UART_TX_PARITY_EN; parity scenarios run only when it is defined.
module tb_uart_tx_fifo;

   localparam int CPB   = 10;
   localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] sData = '0;
   logic       sValid = 1'b0;
   logic       sReady;
   logic [1:0] parityMode = 2'b00;
   logic       tx, txBusy;
   logic [4:0] fifoLevel;

   logic [4:0] sData5 = '0;
   logic       sValid5 = 1'b0;
   logic       sReady5, tx5, txBusy5;
   logic [2:0] fifoLevel5;

   int checks = 0;
   int failures = 0;

   logic [15:0] centres;
   int          busyLen;

   always #5 clk = ~clk;

   uart_tx_fifo #(
      .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .s_data(sData), .s_valid(sValid), .s_ready(sReady),
`ifdef UART_TX_PARITY_EN
      .parity_mode(parityMode),
`endif
      .tx(tx), .tx_busy(txBusy), .fifo_level(fifoLevel)
   );

   uart_tx_fifo #(
      .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(5), .STOP_BITS(2), .FIFO_DEPTH(4)
   ) u_dut5 (
      .clk(clk), .rst_n(rst_n), .s_data(sData5), .s_valid(sValid5), .s_ready(sReady5),
`ifdef UART_TX_PARITY_EN
      .parity_mode(2'b00),
`endif
      .tx(tx5), .tx_busy(txBusy5), .fifo_level(fifoLevel5)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [7:0] data);
      sValid = valid;
      sData  = data;
   endtask

   // Model: queued words, plus the remaining line level for every cycle of the frame in flight.
   int modelQ[$];
   bit lineQ[$];
   bit pushNow, popNow;
   int word;

   task automatic buildFrame(input int w, input logic [1:0] mode);
      logic [7:0] wb;
      wb = w[7:0];
      repeat (CPB) lineQ.push_back(1'b0);
      for (int b = 0; b < 8; b++) repeat (CPB) lineQ.push_back(wb[b]);
      if (PAR_EN && (mode == 2'b01 || mode == 2'b10))
         repeat (CPB) lineQ.push_back((^wb) ^ (mode == 2'b10));
      repeat (CPB) lineQ.push_back(1'b1);
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         modelQ.delete();
         lineQ.delete();
      end else begin
         pushNow = sValid && (modelQ.size() != DEPTH);
         if (lineQ.size() != 0) void'(lineQ.pop_front());
         popNow = (lineQ.size() == 0) && (modelQ.size() != 0);
         if (popNow) begin
            word = modelQ.pop_front();
            buildFrame(word, parityMode);
         end
         if (pushNow) modelQ.push_back(int'(sData));
      end
   end

   always @(negedge clk) begin
      checkOutput("model_tx", 32'(tx), (lineQ.size() != 0) ? 32'(lineQ[0]) : 32'd1);
      checkOutput("model_busy", 32'(txBusy), 32'(lineQ.size() != 0));
      checkOutput("model_level", 32'(fifoLevel), 32'(modelQ.size()));
      checkOutput("model_ready", 32'(sReady), 32'(rst_n && (modelQ.size() != DEPTH)));
   end

   // Push one word into the idle 8-bit instance and stop at the first negedge with tx low.
   task automatic sendOne(input logic [7:0] d);
      @(negedge clk); #1 applyStimulus(1'b1, d);
      @(negedge clk);
      checkOutput("push_level", 32'(fifoLevel), 32'd1);
      checkOutput("pre_fall_tx", 32'(tx), 32'd1);
      #1 applyStimulus(1'b0, d);
      @(negedge clk);
      checkOutput("fall_tx", 32'(tx), 32'd0);
      checkOutput("fall_busy", 32'(txBusy), 32'd1);
      checkOutput("fall_level", 32'(fifoLevel), 32'd0);
   endtask

   task automatic sampleFrame(input bit second, input bit toggle, output logic [15:0] c, output int bl);
      int k;
      k  = 0;
      c  = '0;
      bl = 0;
      while (((second ? txBusy5 : txBusy) == 1'b1) && k < 400) begin
         if (k % 10 == 5 && k < 160) c[k / 10] = second ? tx5 : tx;
         if (toggle && k == 30) parityMode = 2'b10;
         if (toggle && k == 60) parityMode = 2'b00;
         bl++;
         k++;
         @(negedge clk);
      end
   endtask

   initial begin
      int sent, maxLevel, busyCycles, lowCount, t;
      bit acceptNext;

      #1 rst_n = 1'b0;
      sValid = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("rst_tx", 32'(tx), 32'd1);
      checkOutput("rst_busy", 32'(txBusy), 32'd0);
      checkOutput("rst_ready", 32'(sReady), 32'd0);
      checkOutput("rst_level", 32'(fifoLevel), 32'd0);
      checkOutput("rst_tx5", 32'(tx5), 32'd1);
      #1 rst_n = 1'b1;
      sValid = 1'b0;
      @(negedge clk);
      checkOutput("release_ready", 32'(sReady), 32'd1);
      repeat (5) @(negedge clk);
      checkOutput("idle_tx", 32'(tx), 32'd1);

      $display("[TB] single byte 0xA5");
      sendOne(8'hA5);
      sampleFrame(1'b0, 1'b0, centres, busyLen);
      checkOutput("a5_bits", 32'(centres), 32'h34A);
      checkOutput("a5_len", 32'(busyLen), 32'd100);

`ifdef UART_TX_PARITY_EN
      $display("[TB] parity frames");
      parityMode = 2'b01;
      sendOne(8'h07);
      sampleFrame(1'b0, 1'b0, centres, busyLen);
      checkOutput("even_bits", 32'(centres), 32'h60E);
      checkOutput("even_len", 32'(busyLen), 32'd110);
      parityMode = 2'b10;
      sendOne(8'h07);
      sampleFrame(1'b0, 1'b0, centres, busyLen);
      checkOutput("odd_bits", 32'(centres), 32'h40E);
      checkOutput("odd_len", 32'(busyLen), 32'd110);
      parityMode = 2'b01;
      sendOne(8'h07);
      sampleFrame(1'b0, 1'b1, centres, busyLen);
      checkOutput("toggle_bits", 32'(centres), 32'h60E);
      checkOutput("toggle_len", 32'(busyLen), 32'd110);
      parityMode = 2'b00;
`endif

      $display("[TB] burst of 20");
      sent = 0; maxLevel = 0; busyCycles = 0; t = 0;
      @(negedge clk); #1 applyStimulus(1'b1, 8'h00);
      while (!(sent == 20 && !txBusy && busyCycles > 0) && t < 3000) begin
         acceptNext = sValid && sReady;
         @(negedge clk);
         t++;
         if (acceptNext) sent++;
         if (int'(fifoLevel) > maxLevel) maxLevel = int'(fifoLevel);
         if (txBusy) busyCycles++;
         #1;
         if (sent == 20) applyStimulus(1'b0, 8'h00);
         else applyStimulus(1'b1, 8'(sent));
      end
      checkOutput("burst_sent", 32'(sent), 32'd20);
      checkOutput("burst_max_level", 32'(maxLevel), 32'd16);
      checkOutput("burst_busy_cycles", 32'(busyCycles), 32'd2000);

      $display("[TB] 5 data bits, 2 stop bits");
      @(negedge clk); #1 sValid5 = 1'b1; sData5 = 5'h1F;
      @(negedge clk); #1 sValid5 = 1'b0;
      @(negedge clk);
      checkOutput("d5_fall", 32'(tx5), 32'd0);
      sampleFrame(1'b1, 1'b0, centres, busyLen);
      checkOutput("d5_bits", 32'(centres), 32'hFE);
      checkOutput("d5_len", 32'(busyLen), 32'd80);

      $display("[TB] reset mid-frame");
      @(negedge clk); #1 applyStimulus(1'b1, 8'h3C);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk); #1 sData = 8'h3C + 8'(i);
      end
      @(negedge clk); #1 applyStimulus(1'b0, 8'h00);
      checkOutput("pre_rst_level", 32'(fifoLevel), 32'd3);
      repeat (33) @(negedge clk);
      checkOutput("pre_rst_busy", 32'(txBusy), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("midrst_tx", 32'(tx), 32'd1);
      checkOutput("midrst_level", 32'(fifoLevel), 32'd0);
      checkOutput("midrst_busy", 32'(txBusy), 32'd0);
      checkOutput("midrst_ready", 32'(sReady), 32'd0);
      @(negedge clk); #1 rst_n = 1'b1;
      lowCount = 0;
      repeat (300) begin
         @(negedge clk);
         if (!tx) lowCount++;
      end
      checkOutput("no_restart", 32'(lowCount), 32'd0);

      $display("[TB] random traffic");
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk); #1;
         applyStimulus($urandom_range(0, 39) == 0, 8'($urandom));
         parityMode = 2'($urandom);
      end
      applyStimulus(1'b0, 8'h00);
      t = 0;
      while ((txBusy || fifoLevel != 0) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      checkOutput("drain_done", 32'(t < 3000), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      failures++;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
